instruction_decode_stage: RTL

//   Pipeline stage directly downstream of instruction fetch. Registers the fetched

---
 rtl/instruction_decode_stage.sv | 137 +++++++++++++
 1 files changed

// File: rtl/instruction_decode_stage.sv
// Instruction decode stage: registers the fetched instruction and PC, splits
// the instruction fields, reads a 32x32 register file with write-through
// bypass, and resolves unconditional absolute jumps back to fetch. The one
// wrong-path instruction fetched behind a jump is squashed.
module instruction_decode_stage #(
  parameter int          DATA_W      = 32,
  parameter int          REG_ADDR_W  = 5,
  parameter int          NUM_REGS    = 32,
  parameter logic [5:0]  JUMP_OPCODE = 6'b000010
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_valid,
  input  logic [DATA_W-1:0]     if_instruction,
  input  logic [DATA_W-1:0]     if_pc,
  input  logic                  id_stall,
  input  logic                  id_flush,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  id_valid,
  output logic [5:0]            id_opcode,
  output logic [REG_ADDR_W-1:0] id_rs_addr,
  output logic [REG_ADDR_W-1:0] id_rt_addr,
  output logic [REG_ADDR_W-1:0] id_rd_addr,
  output logic [DATA_W-1:0]     id_rs_data,
  output logic [DATA_W-1:0]     id_rt_data,
  output logic [DATA_W-1:0]     id_imm,
  output logic [DATA_W-1:0]     id_pc,
  output logic                  jump_taken,
  output logic [DATA_W-1:0]     jump_target
);

  typedef enum logic {RUN, SQUASH} state_t;

  state_t                  state;
  logic [DATA_W-1:0]       regs [NUM_REGS];

  logic [5:0]              opcode_p0;
  logic [REG_ADDR_W-1:0]   rs_addr_p0;
  logic [REG_ADDR_W-1:0]   rt_addr_p0;
  logic [DATA_W-1:0]       rs_read_p0;
  logic [DATA_W-1:0]       rt_read_p0;
  logic                    capture_p0;

  logic                    vld_p1;
  logic [DATA_W-1:0]       instr_p1;
  logic [DATA_W-1:0]       pc_p1;
  logic [DATA_W-1:0]       rs_data_p1;
  logic [DATA_W-1:0]       rt_data_p1;
  logic                    jump_p1;

  // Sign-extend the 16-bit immediate to the datapath width.
  function automatic logic [DATA_W-1:0] sign_ext16(input logic signed [15:0] imm);
    logic signed [DATA_W-1:0] wide;
    wide = DATA_W'(imm);
    return wide;
  endfunction

  // ---- Stage p0: field split and bypassed register reads of the incoming instruction
  assign opcode_p0  = if_instruction[31:26];
  assign rs_addr_p0 = if_instruction[25:21];
  assign rt_addr_p0 = if_instruction[20:16];
  assign capture_p0 = !id_stall && !id_flush;

  // Combinational reads; a same-cycle writeback to the read index wins over the array.
  always_comb begin
    rs_read_p0 = '0;
    rt_read_p0 = '0;
    if (rs_addr_p0 != '0)
      rs_read_p0 = (wb_en && wb_addr == rs_addr_p0) ? wb_data : regs[rs_addr_p0];
    if (rt_addr_p0 != '0)
      rt_read_p0 = (wb_en && wb_addr == rt_addr_p0) ? wb_data : regs[rt_addr_p0];
  end

  // Register file write port; r0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // ---- Stage p1: pipeline register, squash FSM and jump pulse
  // Flush beats stall; a held instruction keeps tracking writebacks to its sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      vld_p1     <= 1'b0;
      instr_p1   <= '0;
      pc_p1      <= '0;
      rs_data_p1 <= '0;
      rt_data_p1 <= '0;
      jump_p1    <= 1'b0;
    end else begin
      jump_p1 <= 1'b0;
      if (id_flush) begin
        vld_p1 <= 1'b0;
        state  <= RUN;
      end else if (id_stall) begin
        if (vld_p1 && wb_en && wb_addr != '0) begin
          if (wb_addr == instr_p1[25:21]) rs_data_p1 <= wb_data;
          if (wb_addr == instr_p1[20:16]) rt_data_p1 <= wb_data;
        end
      end else if (capture_p0) begin
        instr_p1   <= if_instruction;
        pc_p1      <= if_pc;
        rs_data_p1 <= rs_read_p0;
        rt_data_p1 <= rt_read_p0;
        if (state == SQUASH) begin
          vld_p1 <= 1'b0;
          state  <= RUN;
        end else begin
          vld_p1 <= if_valid;
          if (if_valid && opcode_p0 == JUMP_OPCODE) begin
            state   <= SQUASH;
            jump_p1 <= 1'b1;
          end
        end
      end
    end
  end

  assign id_valid    = vld_p1;
  assign id_opcode   = instr_p1[31:26];
  assign id_rs_addr  = instr_p1[25:21];
  assign id_rt_addr  = instr_p1[20:16];
  assign id_rd_addr  = instr_p1[15:11];
  assign id_rs_data  = rs_data_p1;
  assign id_rt_data  = rt_data_p1;
  assign id_imm      = sign_ext16(instr_p1[15:0]);
  assign id_pc       = pc_p1;
  assign jump_taken  = jump_p1;
  assign jump_target = {pc_p1[DATA_W-1:DATA_W-6], instr_p1[25:0]};

endmodule
